// File: rtl/lamp_phase_timer.sv
// lamp_phase_timer: paces the cyclic lamp sequencer through RED -> GREEN -> YELLOW.
// Each phase is held for a programmed number of cycles. A one-cycle 'step' pulse marks
// every phase change. A latched pedestrian request shortens GREEN to MIN_GREEN cycles
// and is acknowledged when the sequence re-enters RED.
module lamp_phase_timer #(
    parameter int CNT_W        = 8,
    parameter int RED_TICKS    = 16,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int MIN_GREEN    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ped_req,
    output logic             step,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_ack
);

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_RED     = 2'd2,
        PH_ILLEGAL = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    // GREEN may be cut short once 'remaining' has dropped to this value,
    // i.e. once at least MIN_GREEN cycles of GREEN have elapsed.
    localparam logic [CNT_W-1:0] SHORT_LIM   = CNT_W'(GREEN_TICKS - MIN_GREEN);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             step_q, step_d;
    logic             ack_q, ack_d;
    logic             pend_q, pend_d;
    phase_e           next_ph;
    logic             adv;

    // Reload value for the counter on entry to a phase.
    function automatic logic [CNT_W-1:0] load_for(input phase_e ph);
        case (ph)
            PH_GREEN:  load_for = GREEN_LOAD;
            PH_YELLOW: load_for = YELLOW_LOAD;
            default:   load_for = RED_LOAD;
        endcase
    endfunction

    // Next-state: phase sequencing, counter reload/decrement, request latch and ack.
    always_comb begin
        phase_d = phase_q;
        rem_d   = rem_q;
        step_d  = 1'b0;
        ack_d   = 1'b0;
        pend_d  = pend_q | ped_req;
        next_ph = PH_RED;

        case (phase_q)
            PH_RED:    next_ph = PH_GREEN;
            PH_GREEN:  next_ph = PH_YELLOW;
            PH_YELLOW: next_ph = PH_RED;
            default:   next_ph = PH_RED;
        endcase

        // An illegal encoding always recovers to RED on the next enabled edge.
        adv = (rem_q == '0)
            || (phase_q == PH_GREEN && pend_q && rem_q <= SHORT_LIM)
            || (phase_q == PH_ILLEGAL);

        if (en) begin
            if (adv) begin
                phase_d = next_ph;
                rem_d   = load_for(next_ph);
                step_d  = 1'b1;
                // Serving the request on RED entry overrides a same-edge new request.
                if (phase_q == PH_YELLOW && pend_q) begin
                    ack_d  = 1'b1;
                    pend_d = 1'b0;
                end
            end else begin
                rem_d = rem_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset drops straight into the start of RED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_RED;
            rem_q   <= RED_LOAD;
            step_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    assign step      = step_q;
    assign phase     = phase_q;
    assign remaining = rem_q;
    assign ped_ack   = ack_q;

endmodule

// File: tb/tb_lamp_phase_timer.sv
// Bench for lamp_phase_timer: directed scenarios plus a long randomized run, all checked
// against a behavioural model that tracks phase and time-in-phase.
module tb_lamp_phase_timer;

    localparam int CW = 8;
    localparam int RT = 16;
    localparam int GT = 20;
    localparam int YT = 4;
    localparam int MG = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          ped_req = 1'b0;
    logic          step;
    logic [1:0]    phase;
    logic [CW-1:0] remaining;
    logic          ped_ack;

    int total = 0;
    int bad   = 0;

    // Model state: phase (0 G, 1 Y, 2 R), cycles already spent in it, pending request.
    int m_phase;
    int m_age;
    bit m_pend;
    bit m_step;
    bit m_ack;

    lamp_phase_timer #(
        .CNT_W(CW), .RED_TICKS(RT), .GREEN_TICKS(GT), .YELLOW_TICKS(YT), .MIN_GREEN(MG)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
        .step(step), .phase(phase), .remaining(remaining), .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int p);
        if (p == 0) return GT;
        if (p == 1) return YT;
        return RT;
    endfunction

    task automatic model_reset();
        m_phase = 2; m_age = 0; m_pend = 0; m_step = 0; m_ack = 0;
    endtask

    // One clock edge of the lamp rules: a phase lasts its duration, GREEN ends early
    // once MIN_GREEN cycles have passed with a request pending.
    task automatic model_edge(input bit e, input bit r);
        bit go;
        if (e) begin
            go = (m_age == dur(m_phase) - 1) || (m_phase == 0 && m_pend && m_age >= MG - 1);
            m_ack = go && (m_phase == 1) && m_pend;
            m_pend = m_ack ? 1'b0 : (m_pend | r);
            m_step = go;
            if (go) begin
                m_phase = (m_phase == 2) ? 0 : (m_phase == 0) ? 1 : 2;
                m_age = 0;
            end else begin
                m_age = m_age + 1;
            end
        end else begin
            m_step = 0;
            m_ack = 0;
            if (r) m_pend = 1;
        end
    endtask

    function automatic logic [CW+3:0] expv();
        return {2'(m_phase), CW'(dur(m_phase) - 1 - m_age), m_step, m_ack};
    endfunction

    task automatic tick(input bit e, input bit r);
        en = e;
        ped_req = r;
        @(posedge clk);
        model_edge(e, r);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({phase, remaining, step, ped_ack} !== {2'd2, 8'd15, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", {phase, remaining, step, ped_ack},
                     {2'd2, 8'd15, 1'b0, 1'b0});
        end
    endtask

    task automatic test_normal_cycle();
        int steps[$];
        apply_reset();
        for (int i = 1; i <= 80; i++) begin
            tick(1, 0);
            total++;
            if ({phase, remaining, step, ped_ack} !== expv()) begin
                bad++;
                $display("FAIL normal_model edge=%0d got=%h exp=%h", i,
                         {phase, remaining, step, ped_ack}, expv());
            end
            if (step) steps.push_back(i);
            if (i == 16) begin
                total++;
                if ({phase, remaining, step} !== {2'd0, 8'd19, 1'b1}) begin
                    bad++;
                    $display("FAIL first_green got=%h exp=%h", {phase, remaining, step},
                             {2'd0, 8'd19, 1'b1});
                end
            end
        end
        total++;
        if (steps.size() != 6 || steps[0] != 16 || steps[1] != 36 || steps[2] != 40
            || steps[3] != 56 || steps[4] != 76 || steps[5] != 80) begin
            bad++;
            $display("FAIL step_edges got=%p exp=16,36,40,56,76,80", steps);
        end
    endtask

    task automatic test_ped_green();
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            tick(1, i == 17);
            total++;
            if ({phase, remaining, step, ped_ack} !== expv()) begin
                bad++;
                $display("FAIL ped_green_model edge=%0d got=%h exp=%h", i,
                         {phase, remaining, step, ped_ack}, expv());
            end
            if (i == 22) begin
                total++;
                if ({phase, step} !== {2'd1, 1'b1}) begin
                    bad++;
                    $display("FAIL ped_green_short got=%h exp=%h", {phase, step}, {2'd1, 1'b1});
                end
            end
            if (i == 26 || i == 27) begin
                total++;
                if ({phase, ped_ack} !== {2'd2, (i == 26)}) begin
                    bad++;
                    $display("FAIL ped_green_ack edge=%0d got=%h exp=%h", i, {phase, ped_ack},
                             {2'd2, (i == 26)});
                end
            end
        end
    endtask

    task automatic test_ped_late();
        apply_reset();
        for (int i = 1; i <= 36; i++) begin
            tick(1, i == 30);
            total++;
            if ({phase, remaining, step, ped_ack} !== expv()) begin
                bad++;
                $display("FAIL ped_late_model edge=%0d got=%h exp=%h", i,
                         {phase, remaining, step, ped_ack}, expv());
            end
            if (i == 31) begin
                total++;
                if ({phase, step} !== {2'd1, 1'b1}) begin
                    bad++;
                    $display("FAIL ped_late_yellow got=%h exp=%h", {phase, step}, {2'd1, 1'b1});
                end
            end
            if (i == 35) begin
                total++;
                if ({phase, ped_ack} !== {2'd2, 1'b1}) begin
                    bad++;
                    $display("FAIL ped_late_ack got=%h exp=%h", {phase, ped_ack}, {2'd2, 1'b1});
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        for (int pass = 0; pass < 2; pass++) begin
            int first_step;
            first_step = 0;
            apply_reset();
            for (int i = 1; i <= 30; i++) begin
                tick(!(i >= 5 && i <= 9), (pass == 1) && (i == 6));
                total++;
                if ({phase, remaining, step, ped_ack} !== expv()) begin
                    bad++;
                    $display("FAIL freeze_model pass=%0d edge=%0d got=%h exp=%h", pass, i,
                             {phase, remaining, step, ped_ack}, expv());
                end
                if (step && first_step == 0) first_step = i;
                if (i >= 5 && i <= 9) begin
                    total++;
                    if ({remaining, step} !== {8'd11, 1'b0}) begin
                        bad++;
                        $display("FAIL freeze_hold edge=%0d got=%h exp=%h", i, {remaining, step},
                                 {8'd11, 1'b0});
                    end
                end
                if (pass == 1 && (i == 26 || i == 27)) begin
                    total++;
                    if (phase !== ((i == 27) ? 2'd1 : 2'd0)) begin
                        bad++;
                        $display("FAIL freeze_latched_req edge=%0d got=%0d exp=%0d", i, phase,
                                 (i == 27) ? 1 : 0);
                    end
                end
            end
            total++;
            if (first_step != 21) begin
                bad++;
                $display("FAIL freeze_first_step got=%0d exp=21", first_step);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 1; i <= 28; i++) tick(1, 0);
        total++;
        if ({phase, remaining} !== {2'd0, 8'd7}) begin
            bad++;
            $display("FAIL async_pre got=%h exp=%h", {phase, remaining}, {2'd0, 8'd7});
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({phase, remaining, step, ped_ack} !== {2'd2, 8'd15, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", {phase, remaining, step, ped_ack},
                     {2'd2, 8'd15, 1'b0, 1'b0});
        end
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 20; i++) begin
            tick(1, 0);
            total++;
            if ({phase, remaining, step, ped_ack} !== expv()) begin
                bad++;
                $display("FAIL async_after edge=%0d got=%h exp=%h", i,
                         {phase, remaining, step, ped_ack}, expv());
            end
        end
    endtask

    task automatic test_ack_collision();
        int acks;
        acks = 0;
        apply_reset();
        for (int i = 1; i <= 65; i++) begin
            tick(1, (i == 3) || (i == 26));
            total++;
            if ({phase, remaining, step, ped_ack} !== expv()) begin
                bad++;
                $display("FAIL collide_model edge=%0d got=%h exp=%h", i,
                         {phase, remaining, step, ped_ack}, expv());
            end
            if (ped_ack) acks++;
            if (i == 26) begin
                total++;
                if ({phase, ped_ack} !== {2'd2, 1'b1}) begin
                    bad++;
                    $display("FAIL collide_ack got=%h exp=%h", {phase, ped_ack}, {2'd2, 1'b1});
                end
            end
            if (i == 61 || i == 62) begin
                total++;
                if (phase !== ((i == 62) ? 2'd1 : 2'd0)) begin
                    bad++;
                    $display("FAIL collide_full_green edge=%0d got=%0d exp=%0d", i, phase,
                             (i == 62) ? 1 : 0);
                end
            end
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL collide_ack_count got=%0d exp=1", acks);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 1; i <= 2000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0);
            total++;
            if ({phase, remaining, step, ped_ack} !== expv()) begin
                bad++;
                $display("FAIL random_model cycle=%0d got=%h exp=%h", i,
                         {phase, remaining, step, ped_ack}, expv());
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;
        test_reset();
        test_normal_cycle();
        test_ped_green();
        test_ped_late();
        test_enable_freeze();
        test_async_reset();
        test_ack_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
